// File: rtl/eth_frame_receiver.sv
// Byte-serial Ethernet receive parser: strips preamble/SFD, captures header fields and the
// first payload word, counts payload bytes and checks the FCS residue of each frame.
`timescale 1ns/1ps

module eth_frame_receiver #(
  parameter int MIN_PREAMBLE = 7,
  parameter int MAX_PAYLOAD  = 1500,
  parameter int LEN_W        = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_dv,
  input  logic [7:0]       rx_data,
  output logic [47:0]      dest_addr,
  output logic [47:0]      src_addr,
  output logic [15:0]      eth_type,
  output logic [31:0]      data_out,
  output logic [LEN_W-1:0] payload_len,
  output logic             rx_done,
  output logic             rx_err,
  output logic [2:0]       err_code,
  output logic             busy
);

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    HEADER,
    BODY,
    DROP
  } state_t;

  localparam logic [31:0]      CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0]      CRC_RESIDUE = 32'hDEBB_20E3;
  localparam logic [LEN_W-1:0] MAX_LEN     = LEN_W'(MAX_PAYLOAD);
  localparam logic [3:0]       MIN_PRE     = 4'(MIN_PREAMBLE);

  localparam logic [2:0] ERR_PREAMBLE = 3'd1;
  localparam logic [2:0] ERR_RUNT     = 3'd2;
  localparam logic [2:0] ERR_OVERSIZE = 3'd3;
  localparam logic [2:0] ERR_FCS      = 3'd4;

  state_t      state, state_next;
  logic [3:0]  pre_cnt;
  logic [3:0]  hdr_cnt;
  logic [2:0]  dly_cnt;
  logic [31:0] dly_line;
  logic [31:0] crc;

  logic        sfd_hit;
  logic        commit;
  logic        done_set;
  logic        err_set;
  logic [2:0]  err_val;

  // Reflected CRC-32, one byte per call, LSB of the byte first.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB8_8320;
      else             r = r >> 1;
    end
    return r;
  endfunction

  assign busy = (state != IDLE);

  always_comb begin
    state_next = state;
    sfd_hit    = 1'b0;
    commit     = 1'b0;
    done_set   = 1'b0;
    err_set    = 1'b0;
    err_val    = 3'd0;
    case (state)
      IDLE: begin
        if (rx_dv) state_next = (rx_data == 8'h55) ? PREAMBLE : DROP;
      end
      PREAMBLE: begin
        if (!rx_dv) begin
          err_set    = 1'b1;
          err_val    = ERR_PREAMBLE;
          state_next = IDLE;
        end else if (rx_data != 8'h55) begin
          if (rx_data == 8'hD5 && pre_cnt >= MIN_PRE) begin
            sfd_hit    = 1'b1;
            state_next = HEADER;
          end else begin
            err_set    = 1'b1;
            err_val    = ERR_PREAMBLE;
            state_next = DROP;
          end
        end
      end
      HEADER: begin
        if (!rx_dv) begin
          err_set    = 1'b1;
          err_val    = ERR_RUNT;
          state_next = IDLE;
        end else if (hdr_cnt == 4'd13) begin
          state_next = BODY;
        end
      end
      BODY: begin
        if (!rx_dv) begin
          state_next = IDLE;
          if (dly_cnt != 3'd4) begin
            err_set = 1'b1;
            err_val = ERR_RUNT;
          end else if (crc != CRC_RESIDUE) begin
            err_set = 1'b1;
            err_val = ERR_FCS;
          end else begin
            done_set = 1'b1;
          end
        end else if (dly_cnt == 3'd4) begin
          // The last four body bytes are the FCS, so a byte only counts as payload once four more follow it.
          if (payload_len == MAX_LEN) begin
            err_set    = 1'b1;
            err_val    = ERR_OVERSIZE;
            state_next = DROP;
          end else begin
            commit = 1'b1;
          end
        end
      end
      DROP: begin
        if (!rx_dv) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pre_cnt     <= 4'd0;
      hdr_cnt     <= 4'd0;
      dly_cnt     <= 3'd0;
      dly_line    <= 32'd0;
      crc         <= CRC_INIT;
      dest_addr   <= 48'd0;
      src_addr    <= 48'd0;
      eth_type    <= 16'd0;
      data_out    <= 32'd0;
      payload_len <= '0;
      rx_done     <= 1'b0;
      rx_err      <= 1'b0;
      err_code    <= 3'd0;
    end else begin
      state   <= state_next;
      rx_done <= done_set;
      rx_err  <= err_set;
      if (err_set) err_code <= err_val;

      if (state == IDLE && rx_dv && rx_data == 8'h55) pre_cnt <= 4'd1;
      if (state == PREAMBLE && rx_dv && rx_data == 8'h55 && pre_cnt != 4'd15)
        pre_cnt <= pre_cnt + 4'd1;

      if (sfd_hit) begin
        hdr_cnt     <= 4'd0;
        dly_cnt     <= 3'd0;
        dly_line    <= 32'd0;
        crc         <= CRC_INIT;
        data_out    <= 32'd0;
        payload_len <= '0;
        err_code    <= 3'd0;
      end

      if (state == HEADER && rx_dv) begin
        crc     <= crc_byte(crc, rx_data);
        hdr_cnt <= hdr_cnt + 4'd1;
        if (hdr_cnt < 4'd6)       dest_addr <= {dest_addr[39:0], rx_data};
        else if (hdr_cnt < 4'd12) src_addr  <= {src_addr[39:0], rx_data};
        else                      eth_type  <= {eth_type[7:0], rx_data};
      end

      if (state == BODY && rx_dv) begin
        crc      <= crc_byte(crc, rx_data);
        dly_line <= {dly_line[23:0], rx_data};
        if (dly_cnt != 3'd4) dly_cnt <= dly_cnt + 3'd1;
        if (commit) begin
          payload_len <= payload_len + LEN_W'(1);
          if (payload_len < LEN_W'(4)) begin
            case (payload_len[1:0])
              2'd0:    data_out[31:24] <= dly_line[31:24];
              2'd1:    data_out[23:16] <= dly_line[31:24];
              2'd2:    data_out[15:8]  <= dly_line[31:24];
              default: data_out[7:0]   <= dly_line[31:24];
            endcase
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_eth_frame_receiver.sv
// Self-checking bench for eth_frame_receiver: directed and random frames are judged against
// a frame-level reference model that parses the whole byte sequence at once.
`timescale 1ns/1ps

module tb_eth_frame_receiver;

  localparam int LEN_W = 11;

  logic             clk = 1'b0;
  logic             rst;
  logic             rx_dv;
  logic [7:0]       rx_data;
  logic [47:0]      dest_addr;
  logic [47:0]      src_addr;
  logic [15:0]      eth_type;
  logic [31:0]      data_out;
  logic [LEN_W-1:0] payload_len;
  logic             rx_done;
  logic             rx_err;
  logic [2:0]       err_code;
  logic             busy;

  eth_frame_receiver #(
    .MIN_PREAMBLE(7),
    .MAX_PAYLOAD (1500),
    .LEN_W       (LEN_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_dv      (rx_dv),
    .rx_data    (rx_data),
    .dest_addr  (dest_addr),
    .src_addr   (src_addr),
    .eth_type   (eth_type),
    .data_out   (data_out),
    .payload_len(payload_len),
    .rx_done    (rx_done),
    .rx_err     (rx_err),
    .err_code   (err_code),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int err_cyc = -1;
  int sfd_edge = -1;
  int last_edge = -1;
  logic [2:0] last_code = 3'd0;
  logic prev_done = 1'b0;
  logic prev_err = 1'b0;

  logic [7:0] frm[$];
  logic [7:0] pay[$];
  logic [7:0] saved[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse bookkeeping: counts pulses, notes when the last error arrived, and polices pulse shape.
  always @(negedge clk) begin
    if (rst) begin
      prev_done = 1'b0;
      prev_err  = 1'b0;
    end else begin
      if (rx_done) done_cnt++;
      if (rx_err) begin
        err_cnt++;
        last_code = err_code;
        err_cyc   = cyc;
      end
      if (rx_done || rx_err) begin
        check_output("pulse_exclusive", 64'(rx_done & rx_err), 64'd0);
        check_output("pulse_width", 64'((rx_done & prev_done) | (rx_err & prev_err)), 64'd0);
      end
      prev_done = rx_done;
      prev_err  = rx_err;
    end
  end

  function automatic logic [31:0] fcs_of(input int first, input int last);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = first; i <= last; i++) begin
      c = c ^ {24'd0, frm[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic build_frame(input int npre, input logic [47:0] d, input logic [47:0] s,
                             input logic [15:0] t);
    logic [31:0] f;
    int start;
    frm = {};
    repeat (npre) frm.push_back(8'h55);
    frm.push_back(8'hD5);
    start = frm.size();
    for (int i = 5; i >= 0; i--) frm.push_back(d[8*i +: 8]);
    for (int i = 5; i >= 0; i--) frm.push_back(s[8*i +: 8]);
    frm.push_back(t[15:8]);
    frm.push_back(t[7:0]);
    foreach (pay[i]) frm.push_back(pay[i]);
    f = fcs_of(start, frm.size() - 1);
    frm.push_back(f[7:0]);
    frm.push_back(f[15:8]);
    frm.push_back(f[23:16]);
    frm.push_back(f[31:24]);
  endtask

  // Reference model: parses the complete byte sequence and states the frame's verdict.
  task automatic predict(output bit e_done, output bit e_err, output logic [2:0] e_code,
                         output logic [47:0] e_dst, output logic [47:0] e_src,
                         output logic [15:0] e_typ, output logic [31:0] e_data, output int e_len);
    int n, sz, body;
    logic [31:0] fcs_rx;
    e_done = 1'b0; e_err = 1'b0; e_code = 3'd0;
    e_dst = 48'd0; e_src = 48'd0; e_typ = 16'd0; e_data = 32'd0; e_len = 0;
    sz = frm.size();
    if (sz == 0 || frm[0] != 8'h55) return;
    n = 0;
    while (n < sz && frm[n] == 8'h55) n++;
    if (n == sz || frm[n] != 8'hD5 || n < 7) begin
      e_err = 1'b1; e_code = 3'd1;
      return;
    end
    if (sz - n - 1 < 18) begin
      e_err = 1'b1; e_code = 3'd2;
      return;
    end
    body  = sz - n - 1 - 14;
    e_len = body - 4;
    for (int i = 0; i < 6; i++) e_dst = {e_dst[39:0], frm[n + 1 + i]};
    for (int i = 0; i < 6; i++) e_src = {e_src[39:0], frm[n + 7 + i]};
    e_typ = {frm[n + 13], frm[n + 14]};
    for (int i = 0; i < 4; i++) if (i < e_len) e_data[31 - 8*i -: 8] = frm[n + 15 + i];
    if (e_len > 1500) begin
      e_err = 1'b1; e_code = 3'd3;
      return;
    end
    fcs_rx = {frm[sz - 1], frm[sz - 2], frm[sz - 3], frm[sz - 4]};
    if (fcs_rx != fcs_of(n + 1, sz - 5)) begin
      e_err = 1'b1; e_code = 3'd4;
    end else begin
      e_done = 1'b1;
    end
  endtask

  task automatic apply_stimulus();
    sfd_edge = -1;
    foreach (frm[i]) begin
      @(posedge clk); #1;
      rx_dv     = 1'b1;
      rx_data   = frm[i];
      last_edge = cyc + 1;
      if (frm[i] == 8'hD5 && sfd_edge < 0) sfd_edge = cyc + 1;
    end
    @(posedge clk); #1;
    rx_dv   = 1'b0;
    rx_data = 8'h00;
  endtask

  task automatic check_frame(input string tag);
    bit e_done, e_err;
    logic [2:0] e_code;
    logic [47:0] e_dst, e_src;
    logic [15:0] e_typ;
    logic [31:0] e_data;
    int e_len;
    predict(e_done, e_err, e_code, e_dst, e_src, e_typ, e_data, e_len);
    done_cnt = 0;
    err_cnt  = 0;
    apply_stimulus();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output({tag, "/done_count"}, 64'(done_cnt), 64'(e_done));
    check_output({tag, "/err_count"}, 64'(err_cnt), 64'(e_err));
    check_output({tag, "/busy_after"}, 64'(busy), 64'd0);
    if (e_err) check_output({tag, "/err_code"}, 64'(last_code), 64'(e_code));
    if (e_done || e_code == 3'd4) begin
      check_output({tag, "/dest_addr"}, 64'(dest_addr), 64'(e_dst));
      check_output({tag, "/src_addr"}, 64'(src_addr), 64'(e_src));
      check_output({tag, "/eth_type"}, 64'(eth_type), 64'(e_typ));
      check_output({tag, "/data_out"}, 64'(data_out), 64'(e_data));
      check_output({tag, "/payload_len"}, 64'(payload_len), 64'(e_len));
    end
    if (e_done) check_output({tag, "/err_code_clear"}, 64'(err_code), 64'd0);
  endtask

  initial begin
    int kind, plen, idx;
    logic [7:0] junk;

    rst = 1'b1; rx_dv = 1'b0; rx_data = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("reset/dest_addr", 64'(dest_addr), 64'd0);
    check_output("reset/src_addr", 64'(src_addr), 64'd0);
    check_output("reset/outputs", 64'({eth_type, data_out, payload_len, rx_done, rx_err, err_code, busy}), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Reference good frame: DEADBEEF plus 42 zero bytes.
    pay = {8'hDE, 8'hAD, 8'hBE, 8'hEF};
    repeat (42) pay.push_back(8'h00);
    build_frame(7, 48'h1234_5678_9ABC, 48'hABCD_EF12_3456, 16'h0800);
    check_frame("good_46");
    check_output("good_46/data_const", 64'(data_out), 64'hDEAD_BEEF);
    check_output("good_46/len_const", 64'(payload_len), 64'd46);

    frm[frm.size() - 4] = frm[frm.size() - 4] ^ 8'h01;
    check_frame("bad_fcs");

    // Short preamble: error lands on the edge that consumes the SFD; busy drops one edge after rx_dv.
    pay = {8'h11, 8'h22, 8'h33};
    build_frame(5, 48'h1, 48'h2, 16'h3);
    done_cnt = 0; err_cnt = 0;
    apply_stimulus();
    @(negedge clk);
    check_output("short_pre/busy_hold", 64'(busy), 64'd1);
    @(negedge clk);
    check_output("short_pre/busy_drop", 64'(busy), 64'd0);
    repeat (2) @(negedge clk);
    check_output("short_pre/err_count", 64'(err_cnt), 64'd1);
    check_output("short_pre/err_code", 64'(last_code), 64'd1);
    check_output("short_pre/err_cycle", 64'(err_cyc), 64'(sfd_edge));
    check_output("short_pre/done_count", 64'(done_cnt), 64'd0);

    pay = {};
    build_frame(7, 48'hA, 48'hB, 16'hC);
    while (frm.size() > 8 + 10) void'(frm.pop_back());
    check_frame("hdr_trunc");

    pay = {8'h01, 8'h02};
    build_frame(7, 48'hA, 48'hB, 16'hC);
    repeat (4) void'(frm.pop_back());
    check_frame("runt_2");

    pay = {};
    repeat (1501) pay.push_back(8'($urandom));
    build_frame(7, 48'h0A0B_0C0D_0E0F, 48'h1, 16'h86DD);
    check_frame("oversize");
    check_output("oversize/err_cycle", 64'(err_cyc), 64'(last_edge));

    void'(pay.pop_back());
    build_frame(8, 48'h0A0B_0C0D_0E0F, 48'h1, 16'h86DD);
    check_frame("max_1500");

    pay = {};
    build_frame(7, 48'hFFFF_FFFF_FFFF, 48'h5, 16'h0806);
    check_frame("empty_payload");

    // Two good frames with only the mandatory single idle cycle between them.
    pay = {8'hC0, 8'hFF, 8'hEE};
    build_frame(7, 48'h11, 48'h22, 16'h0800);
    saved = frm;
    done_cnt = 0; err_cnt = 0;
    apply_stimulus();
    pay = {8'h99};
    build_frame(9, 48'h33, 48'h44, 16'h0800);
    apply_stimulus();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("back2back/done_count", 64'(done_cnt), 64'd2);
    check_output("back2back/data_out", 64'(data_out), 64'h9900_0000);
    check_output("back2back/payload_len", 64'(payload_len), 64'd1);

    // Reset in the middle of a body, released while the line is still busy.
    pay = {};
    repeat (20) pay.push_back(8'($urandom));
    build_frame(8, 48'h77, 48'h88, 16'h0800);
    done_cnt = 0; err_cnt = 0;
    for (int i = 0; i < 8 + 1 + 14 + 10; i++) begin
      @(posedge clk); #1;
      rx_dv = 1'b1; rx_data = frm[i];
    end
    @(posedge clk); #1;
    rx_data = 8'h00; rst = 1'b1;
    @(negedge clk);
    check_output("mid_reset/addrs", 64'(dest_addr | src_addr), 64'd0);
    check_output("mid_reset/outputs", 64'({eth_type, data_out, payload_len, rx_done, rx_err, err_code, busy}), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check_output("mid_reset/drop_busy", 64'(busy), 64'd1);
    rx_dv = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("mid_reset/idle", 64'(busy), 64'd0);
    check_output("mid_reset/no_pulse", 64'(done_cnt + err_cnt), 64'd0);
    frm = saved;
    check_frame("after_reset");

    for (int r = 0; r < 14; r++) begin
      kind = int'($urandom_range(0, 5));
      plen = int'($urandom_range(0, 60));
      pay = {};
      repeat (plen) pay.push_back(8'($urandom));
      build_frame((kind == 5) ? int'($urandom_range(7, 20)) : 7,
                  {$urandom, $urandom}, {$urandom, $urandom}, 16'($urandom));
      case (kind)
        1: begin
          idx = 8 + int'($urandom_range(0, 17 + plen));
          frm[idx] = frm[idx] ^ (8'd1 << $urandom_range(0, 7));
        end
        2: begin
          repeat (7 - int'($urandom_range(1, 6))) void'(frm.pop_front());
        end
        3: begin
          idx = 8 + int'($urandom_range(0, 17));
          while (frm.size() > idx) void'(frm.pop_back());
        end
        4: begin
          junk = 8'($urandom);
          if (junk == 8'h55) junk = 8'h54;
          frm.push_front(junk);
        end
        default: ;
      endcase
      check_frame($sformatf("rand%0d_k%0d", r, kind));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
